fetch_stage: RTL and testbench

//  IF stage of the 5-stage MIPS pipe: owns the PC, issues instruction-memory reads, buffers returned words.

---
 rtl/fetch_stage_pkg.sv | 16 +
 rtl/fetch_fifo.sv | 55 +++++
 rtl/fetch_stage.sv | 136 +++++++++++++
 tb/tb_fetch_stage.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the MIPS IF stage: word width, NOP encoding, reset PC
// and the IF/ID record layout.
package fetch_stage_pkg;
    localparam int              WORD             = 32;
    localparam logic [WORD-1:0] NOP_INSTRUCTION  = 32'h0000_0000;
    localparam logic [WORD-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [WORD-1:0] pc_plus_four;
        logic [WORD-1:0] instr;
    } ifid_t;

    function automatic logic [WORD-1:0] word_align(input logic [WORD-1:0] a);
        return {a[WORD-1:2], 2'b00};
    endfunction
endpackage

// File: rtl/fetch_fifo.sv
// Small circular FIFO with flush; head is visible combinationally so the
// consumer can use it in the same cycle it pops.
module fetch_fifo #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 32,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [CW-1:0]    count_o,
    output logic [WIDTH-1:0] head_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_q, wr_q;
    logic [CW-1:0]    cnt_q;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) begin
                wr_q <= bump(wr_q);
            end
            if (pop_i) begin
                rd_q <= bump(rd_q);
            end
            cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
        end
    end

    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_q];
endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, issues credit-limited instruction reads, buffers the
// returned words and feeds the IF/ID register; a taken jump flushes younger fetches.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [WORD-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int              BUF_DEPTH = 2
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            stall,
    input  logic            jump,
    input  logic [WORD-1:0] jump_address,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [WORD-1:0] imem_addr,
    input  logic            imem_resp_valid,
    input  logic [WORD-1:0] imem_resp_data,
    output logic [WORD-1:0] instruction,
    output logic [WORD-1:0] pc_plus_four,
    output logic            fetch_valid
);
    localparam int CW = $clog2(BUF_DEPTH + 1);

    logic [WORD-1:0] pc_q, pc_d;
    logic [CW-1:0]   drop_q, drop_d;
    ifid_t           ifid_q, ifid_d;
    logic            valid_q, valid_d;

    logic [CW-1:0]   inflight_cnt, buf_cnt;
    logic [WORD-1:0] inflight_head;
    ifid_t           buf_head, resp_entry;
    logic [CW:0]     occupancy;
    logic            redirect, credit, req_fire, resp_keep;
    logic            buf_empty, bypass, buf_push, buf_pop;

    assign redirect  = jump & ~stall;
    // Credits cover both words in flight and words parked in the buffer, so
    // every accepted response is guaranteed a buffer slot.
    assign occupancy = {1'b0, inflight_cnt} + {1'b0, buf_cnt};
    assign credit    = occupancy < (CW+1)'(BUF_DEPTH);

    assign imem_req_valid = reset_n & credit & ~redirect;
    assign imem_addr      = pc_q;
    assign req_fire       = imem_req_valid & imem_req_ready;

    assign resp_keep  = imem_resp_valid & (drop_q == '0) & ~redirect;
    assign resp_entry = '{pc_plus_four: inflight_head + 32'd4, instr: imem_resp_data};
    assign buf_empty  = (buf_cnt == '0);
    assign bypass     = resp_keep & buf_empty & ~stall;
    assign buf_push   = resp_keep & ~bypass;
    assign buf_pop    = ~stall & ~redirect & ~buf_empty;

    fetch_fifo #(.DEPTH(BUF_DEPTH), .WIDTH(WORD)) u_inflight (
        .clk_i   (clock),
        .rst_ni  (reset_n),
        .push_i  (req_fire),
        .data_i  (pc_q),
        .pop_i   (imem_resp_valid),
        .flush_i (1'b0),
        .count_o (inflight_cnt),
        .head_o  (inflight_head)
    );

    fetch_fifo #(.DEPTH(BUF_DEPTH), .WIDTH($bits(ifid_t))) u_ibuf (
        .clk_i   (clock),
        .rst_ni  (reset_n),
        .push_i  (buf_push),
        .data_i  (resp_entry),
        .pop_i   (buf_pop),
        .flush_i (redirect),
        .count_o (buf_cnt),
        .head_o  (buf_head)
    );

    always_comb begin
        ifid_d  = ifid_q;
        valid_d = valid_q;
        if (redirect) begin
            ifid_d.instr = NOP_INSTRUCTION;
            valid_d      = 1'b0;
        end else if (!stall) begin
            if (!buf_empty) begin
                ifid_d  = buf_head;
                valid_d = 1'b1;
            end else if (bypass) begin
                ifid_d  = resp_entry;
                valid_d = 1'b1;
            end else begin
                ifid_d.instr = NOP_INSTRUCTION;
                valid_d      = 1'b0;
            end
        end
    end

    // Everything still in flight at a redirect is stale, except a response
    // landing this very cycle, which is discarded directly.
    always_comb begin
        drop_d = drop_q;
        if (redirect) begin
            drop_d = inflight_cnt - CW'(imem_resp_valid);
        end else if (imem_resp_valid && drop_q != '0) begin
            drop_d = drop_q - CW'(1);
        end
    end

    always_comb begin
        pc_d = pc_q;
        if (redirect) begin
            pc_d = word_align(jump_address);
        end else if (req_fire) begin
            pc_d = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_q    <= RESET_PC;
            drop_q  <= '0;
            ifid_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            drop_q  <= drop_d;
            ifid_q  <= ifid_d;
            valid_q <= valid_d;
        end
    end

    assign instruction  = ifid_q.instr;
    assign pc_plus_four = ifid_q.pc_plus_four;
    assign fetch_valid  = valid_q;

    a_resp_has_request: assert property (@(posedge clock) disable iff (!reset_n)
        !(imem_resp_valid && inflight_cnt == '0));
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: queue-based reference model plus directed scenarios
// (streaming, stall, jump, ignored jump, PC wrap, asynchronous reset).
module tb_fetch_stage;
    localparam int BUF_DEPTH = 2;

    logic        clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset_n, stall, jump, imem_req_ready, imem_resp_valid;
    logic [31:0] jump_address, imem_resp_data;
    logic        imem_req_valid, fetch_valid;
    logic [31:0] imem_addr, instruction, pc_plus_four;

    logic        reset_n5, req_valid5, resp_valid5, fv5;
    logic [31:0] addr5, resp_data5, ins5, ppf5;

    fetch_stage #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(BUF_DEPTH)) u_dut (
        .clock(clock), .reset_n(reset_n), .stall(stall), .jump(jump),
        .jump_address(jump_address), .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .instruction(instruction), .pc_plus_four(pc_plus_four), .fetch_valid(fetch_valid)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(BUF_DEPTH)) u_dut5 (
        .clock(clock), .reset_n(reset_n5), .stall(1'b0), .jump(1'b0),
        .jump_address(32'h0), .imem_req_valid(req_valid5),
        .imem_req_ready(1'b1), .imem_addr(addr5),
        .imem_resp_valid(resp_valid5), .imem_resp_data(resp_data5),
        .instruction(ins5), .pc_plus_four(ppf5), .fetch_valid(fv5)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h2001_0005 + (a >> 2);
    endfunction

    // zero-wait memory for the wrap-around instance
    always_ff @(posedge clock or negedge reset_n5) begin
        if (!reset_n5) begin
            resp_valid5 <= 1'b0;
            resp_data5  <= 32'h0;
        end else begin
            resp_valid5 <= req_valid5;
            resp_data5  <= mem_word(addr5);
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct { logic [31:0] addr; int due; } pend_t;
    typedef struct { logic [31:0] ppf; logic [31:0] ins; } ent_t;

    pend_t       mq[$];
    int          cyc = 0;
    int          lat = 1;
    bit          hold = 0;
    logic        nx_stall = 0, nx_jump = 0, nx_ready = 1;
    logic [31:0] nx_jaddr = 0;

    logic [31:0] m_if[$];
    ent_t        m_buf[$];
    int          m_drop;
    logic [31:0] m_pc, m_ins, m_ppf;
    logic        m_fv;

    task automatic model_reset();
        m_if.delete();
        m_buf.delete();
        m_drop = 0;
        m_pc   = 32'h0;
        m_ins  = 32'h0;
        m_ppf  = 32'h0;
        m_fv   = 1'b0;
    endtask

    task automatic cycle();
        ent_t        e;
        logic [31:0] p;
        bit          resp, redirect, kept, exp_rv, fire;
        @(negedge clock);
        cyc++;
        resp = 0;
        if (!hold && mq.size() > 0 && mq[0].due <= cyc) begin
            resp = 1;
            imem_resp_data = mem_word(mq[0].addr);
            void'(mq.pop_front());
        end else begin
            imem_resp_data = 32'hDEAD_BEEF;
        end
        imem_resp_valid = resp;
        stall          = nx_stall;
        jump           = nx_jump;
        jump_address   = nx_jaddr;
        imem_req_ready = nx_ready;
        #1;
        exp_rv = (m_if.size() + m_buf.size() < BUF_DEPTH) && !(jump && !stall);
        chk("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_rv});
        chk("imem_addr", imem_addr, m_pc);
        chk("fetch_valid", {31'b0, fetch_valid}, {31'b0, m_fv});
        if (m_fv) begin
            chk("instruction", instruction, m_ins);
            chk("pc_plus_four", pc_plus_four, m_ppf);
        end else begin
            chk("bubble_instr", instruction, 32'h0);
        end
        chk("outstanding_le_depth", {31'b0, mq.size() <= BUF_DEPTH}, 32'd1);
        if (imem_req_valid && imem_req_ready) mq.push_back('{imem_addr, cyc + lat});

        fire     = exp_rv && imem_req_ready;
        redirect = jump && !stall;
        kept     = 0;
        if (resp && m_if.size() > 0) begin
            p = m_if.pop_front();
            if (redirect || m_drop > 0) begin
                if (!redirect) m_drop--;
            end else begin
                kept  = 1;
                e.ppf = p + 32'd4;
                e.ins = mem_word(p);
            end
        end
        if (fire) begin
            m_if.push_back(m_pc);
            m_pc = m_pc + 32'd4;
        end
        if (redirect) begin
            m_drop = m_if.size();
            m_buf.delete();
            m_fv  = 0;
            m_ins = 32'h0;
            m_pc  = {jump_address[31:2], 2'b00};
        end else begin
            if (kept) m_buf.push_back(e);
            if (!stall) begin
                if (m_buf.size() > 0) begin
                    e     = m_buf.pop_front();
                    m_ins = e.ins;
                    m_ppf = e.ppf;
                    m_fv  = 1;
                end else begin
                    m_fv  = 0;
                    m_ins = 32'h0;
                end
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge clock);
        #3;
        reset_n = 1'b0;
        stall = 0; jump = 0; imem_resp_valid = 0;
        nx_stall = 0; nx_jump = 0; hold = 0;
        #1;
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("rst_instruction", instruction, 32'h0);
        chk("rst_pc_plus_four", pc_plus_four, 32'h0);
        chk("rst_fetch_valid", {31'b0, fetch_valid}, 32'd0);
        mq.delete();
        model_reset();
        repeat (2) @(posedge clock);
        #2 reset_n = 1'b1;
    endtask

    initial begin
        logic [31:0] v;
        reset_n = 0; reset_n5 = 0; stall = 0; jump = 0; jump_address = 0;
        imem_req_ready = 1; imem_resp_valid = 0; imem_resp_data = 0;
        model_reset();
        apply_reset();

        // streaming from reset
        cycle();
        chk("t1_addr0", imem_addr, 32'h0);
        chk("t1_req0", {31'b0, imem_req_valid}, 32'd1);
        cycle();
        chk("t1_addr1", imem_addr, 32'h4);
        cycle();
        chk("t1_fv", {31'b0, fetch_valid}, 32'd1);
        chk("t1_ppf4", pc_plus_four, 32'h4);
        chk("t1_ins0", instruction, 32'h2001_0005);
        cycle();
        chk("t1_ppf8", pc_plus_four, 32'h8);
        chk("t1_ins1", instruction, 32'h2001_0006);
        cycle();
        chk("t1_ppf12", pc_plus_four, 32'hC);

        // three-cycle stall
        nx_stall = 1;
        cycle();
        v = pc_plus_four;
        cycle();
        chk("t2_frozen1", pc_plus_four, v);
        cycle();
        chk("t2_frozen2", pc_plus_four, v);
        nx_stall = 0;
        cycle();
        chk("t2_frozen3", pc_plus_four, v);
        cycle();
        chk("t2_resume", pc_plus_four, v + 32'd4);
        repeat (3) cycle();

        // jump with two stale requests outstanding
        hold = 1;
        cycle();
        cycle();
        nx_jump = 1; nx_jaddr = 32'h0000_0103;
        cycle();
        nx_jump = 0; hold = 0;
        cycle();
        chk("t3_addr_target", imem_addr, 32'h100);
        chk("t3_bubble_fv", {31'b0, fetch_valid}, 32'd0);
        chk("t3_bubble_ins", instruction, 32'h0);
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (fetch_valid) break;
        end
        chk("t3_first_fv", {31'b0, fetch_valid}, 32'd1);
        chk("t3_first_ppf", pc_plus_four, 32'h104);
        chk("t3_first_ins", instruction, 32'h2001_0045);
        repeat (3) cycle();

        // jump while a response lands the same cycle
        nx_jump = 1; nx_jaddr = 32'h0000_0040;
        cycle();
        nx_jump = 0;
        repeat (5) cycle();

        // jump under stall is ignored
        nx_stall = 1; nx_jump = 1; nx_jaddr = 32'h0000_0200;
        cycle();
        nx_stall = 0; nx_jump = 0;
        cycle();
        chk("t4_no_redirect", {31'b0, imem_addr !== 32'h200}, 32'd1);
        repeat (4) cycle();

        // asynchronous reset mid-stream with a response pending
        apply_reset();
        cycle();
        chk("t6_addr0", imem_addr, 32'h0);
        cycle();
        cycle();
        chk("t6_ppf4", pc_plus_four, 32'h4);
        chk("t6_fv", {31'b0, fetch_valid}, 32'd1);
        repeat (2) cycle();

        // PC wrap from a high reset vector
        @(posedge clock);
        #2 reset_n5 = 1'b1;
        @(negedge clock); #1;
        chk("t5_addr0", addr5, 32'hFFFF_FFF8);
        chk("t5_req0", {31'b0, req_valid5}, 32'd1);
        @(negedge clock); #1;
        chk("t5_addr1", addr5, 32'hFFFF_FFFC);
        @(negedge clock); #1;
        chk("t5_addr2", addr5, 32'h0000_0000);
        chk("t5_ppf0", ppf5, 32'hFFFF_FFFC);
        chk("t5_fv", {31'b0, fv5}, 32'd1);
        chk("t5_ins0", ins5, 32'h6001_0003);
        @(negedge clock); #1;
        chk("t5_ppf1", ppf5, 32'h0000_0000);
        @(negedge clock); #1;
        chk("t5_ppf2", ppf5, 32'h0000_0004);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
